// File: rtl/riscv_uart_loader.sv
// Boot loader: UART RX bytes -> little-endian 32-bit words -> sequential instruction-memory writes.
// Write strobe one cycle after the 4th byte; no backpressure, the UART paces everything.
module riscv_uart_loader #(
  parameter int CLK_FREQ       = 23000000,
  parameter int BAUD           = 115200,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 2300000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  start,
  output logic                  cpu_hold,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  err
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]         DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]         HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0]         TMO_M1  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;

  rx_state_t rx_state_q, rx_state_d;
  ld_state_t ld_state_q, ld_state_d;

  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_valid, frame_err, rx_start_evt;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           word_q, word_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]           word_new, wr_word;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  got_byte_q, got_byte_d;
  logic                  fin_pend_q, fin_pend_d;
  logic                  err_q, err_d;
  logic                  mem_we_q, mem_we_d;
  logic                  start_acc, byte_take, tmo_hit, do_write;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_comb begin
    rx_meta_d = uart_rx;
    rx_sync_d = rx_meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!rx_sync_q) rx_state_d = RX_START;
      RX_START: if (baud_cnt_q == HALF_M1) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud_cnt_q == DIV_M1 && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (baud_cnt_q == DIV_M1) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_d   = baud_cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    rx_shift_d   = rx_shift_q;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    rx_start_evt = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        baud_cnt_d   = '0;
        bit_idx_d    = '0;
        rx_start_evt = !rx_sync_q;
      end
      RX_START: if (baud_cnt_q == HALF_M1) baud_cnt_d = '0;
      RX_DATA: begin
        if (baud_cnt_q == DIV_M1) begin
          baud_cnt_d = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_cnt_q == DIV_M1) begin
          baud_cnt_d = '0;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end
      end
      default: baud_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_state_q  <= L_IDLE;
      addr_q      <= '0;
      wc_q        <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      tmo_cnt_q   <= '0;
      got_byte_q  <= 1'b0;
      fin_pend_q  <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ld_state_q  <= ld_state_d;
      addr_q      <= addr_d;
      wc_q        <= wc_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      tmo_cnt_q   <= tmo_cnt_d;
      got_byte_q  <= got_byte_d;
      fin_pend_q  <= fin_pend_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    start_acc = start && (ld_state_q != L_LOAD);
    byte_take = byte_valid && (ld_state_q == L_LOAD) && !fin_pend_q;
    tmo_hit   = (ld_state_q == L_LOAD) && got_byte_q && !fin_pend_q &&
                !rx_start_evt && (tmo_cnt_q == TMO_M1);
  end

  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      L_IDLE: if (start) ld_state_d = L_LOAD;
      L_LOAD: begin
        // A pending finish means the final write is on the bus this cycle.
        if (fin_pend_q) ld_state_d = L_DONE;
        else if (tmo_hit && idx_q == 2'd0) ld_state_d = L_DONE;
      end
      L_DONE: if (start) ld_state_d = L_LOAD;
      default: ld_state_d = L_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold = (ld_state_q == L_LOAD);
    done     = (ld_state_q == L_DONE);
  end

  always_comb begin
    addr_d      = addr_q;
    wc_d        = wc_q;
    idx_d       = idx_q;
    word_d      = word_q;
    tmo_cnt_d   = tmo_cnt_q;
    got_byte_d  = got_byte_q;
    fin_pend_d  = fin_pend_q;
    err_d       = err_q | frame_err;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    word_new    = word_q;
    word_new[{idx_q, 3'b000} +: 8] = rx_shift_q;
    do_write    = 1'b0;
    wr_word     = word_q;
    if (start_acc) begin
      addr_d     = '0;
      wc_d       = '0;
      idx_d      = '0;
      word_d     = '0;
      tmo_cnt_d  = '0;
      got_byte_d = 1'b0;
      fin_pend_d = 1'b0;
      err_d      = 1'b0;
    end else if (ld_state_q == L_LOAD) begin
      if (rx_start_evt) tmo_cnt_d = '0;
      else if (got_byte_q && !fin_pend_q) tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (byte_take) begin
        got_byte_d = 1'b1;
        if (idx_q == 2'd3) begin
          do_write = 1'b1;
          wr_word  = word_new;
        end else begin
          word_d = word_new;
          idx_d  = idx_q + 1'b1;
        end
      end else if (tmo_hit && idx_q != 2'd0) begin
        // Partial word: the untouched upper bytes are still zero from the last clear.
        do_write   = 1'b1;
        fin_pend_d = 1'b1;
      end
      if (do_write) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = wr_word;
        wc_d        = wc_q + 1'b1;
        idx_d       = '0;
        word_d      = '0;
        if (addr_q == ADDR_MAX) fin_pend_d = 1'b1;
        else addr_d = addr_q + 1'b1;
      end
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = wc_q;
  assign err        = err_q;

endmodule

// File: doc/riscv_uart_loader.md
Name: riscv_uart_loader

Overview:
- Boot-time program loader upstream of the instruction fetch stage.
- Receives a raw little-endian binary over a UART RX line and assembles it into 32-bit words.
- Writes each word sequentially into instruction memory through a single-cycle write port.
- Holds the CPU in reset (cpu_hold) while loading and releases it when loading ends by idle timeout or full memory.

Parameters:
- CLK_FREQ, 23000000: clk frequency in Hz (23 MHz core clock).
- BAUD, 115200: UART bit rate.
- ADDR_WIDTH, 14: instruction memory word-address width.
- TIMEOUT_CYCLES, 2300000: idle clk cycles (100 ms) that end a load.

Ports:
- clk  in  1: core clock; all logic on the rising edge.
- rst  in  1: synchronous, active-low reset.
- uart_rx  in  1: asynchronous serial input, idle high.
- start  in  1: one-cycle pulse that begins a load session.
- cpu_hold  out  1: high while loading; ORed into the CPU reset.
- mem_we  out  1: one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_WIDTH: word address for the current write.
- mem_wdata  out  32: word written to memory.
- word_count  out  ADDR_WIDTH+1: words written in the current session.
- done  out  1: high from load completion until the next start.
- err  out  1: sticky framing error; cleared by start or reset.

Behaviour:
- Reset (rst==0 at a clk edge): all outputs 0, both FSMs idle, all counters 0. Reset mid-byte or mid-session abandons it, and no write is issued.
- Baud: DIV = CLK_FREQ/BAUD, integer-truncated; HALF = DIV/2.
- uart_rx passes through a 2-flop synchronizer. The RX FSM sees only the synchronized value (2-cycle input latency).
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on synchronized rx==0.
  - RX_START: after HALF cycles, if rx==0 go to RX_DATA; otherwise treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample every DIV cycles, 8 bits, LSB first.
  - RX_STOP: sample after DIV cycles.
    - rx==1: assert internal byte_valid for 1 cycle.
    - rx==0: set err, discard the byte, return to RX_IDLE.
- The RX FSM runs in all loader states. Bytes are consumed only in L_LOAD.
- Loader FSM states: L_IDLE, L_LOAD, L_DONE.
  - start in L_IDLE or L_DONE: go to L_LOAD. Set cpu_hold=1, done=0, err=0; clear address, word_count, byte index and timeout counter.
  - start in L_LOAD is ignored.
- Byte assembly in L_LOAD:
  - byte_valid places the byte at bits [8*idx+7 : 8*idx] of the word register, then idx increments.
  - On the 4th byte, mem_we=1 on the next cycle with mem_addr=current address and mem_wdata=assembled word.
  - In that same cycle the address increments, word_count increments, and idx returns to 0.
- mem_addr and mem_wdata hold their last values when mem_we is low.
- Timeout:
  - The counter runs in L_LOAD only after at least one byte has been received in the session.
  - It clears on every RX_IDLE -> RX_START transition.
  - On reaching TIMEOUT_CYCLES:
    - idx!=0: write the partial word with unreceived bytes as 0, then go to L_DONE on the following cycle.
    - idx==0: go to L_DONE directly.
  - With no bytes ever received, L_LOAD waits indefinitely.
- Full memory: the write to address 2^ADDR_WIDTH-1 is followed by L_DONE on the next cycle. The address never wraps, and later bytes are ignored.
- L_DONE: cpu_hold=0, done=1. word_count holds its value.
- A framing error does not abort the load. The byte index is unaffected.

Test Plan:
- All scenarios run with CLK_FREQ=1600, BAUD=100 (DIV=16), TIMEOUT_CYCLES=400, ADDR_WIDTH=14 unless stated.
- Reset: hold rst=0 for 3 cycles mid-byte -> all outputs 0. Release, send byte 0xAA with no start pulse -> no mem_we.
- Single word: start pulse, send 0x13,0x05,0x10,0x00 -> exactly one mem_we with mem_addr=0, mem_wdata=0x00100513, word_count=1, cpu_hold=1.
- Timeout with partial word: send 0x11..0x15, then idle -> write 0x14131211@0, then 0x00000015@1 after 400 idle cycles. Then done=1, cpu_hold=0, word_count=2.
- Framing error: send 0x55 with stop bit low -> err=1, no byte counted. Then send 0xEF,0xBE,0xAD,0xDE -> write 0xDEADBEEF@0.
- Glitch: drive rx low for 4 cycles -> no byte_valid, loader state unchanged, no err.
- Full memory (ADDR_WIDTH=2): send 5 words -> 4 writes at addresses 0..3, done=1 after the 4th write, no write for the 5th word, word_count=4. A new start then loads again from address 0.
